// File: rtl/pwm_multi_gen_if.sv
// Register-side bundle for pwm_multi_gen.
//   enable       : global run enable (master -> generator)
//   duty         : packed duty codes, channel i at [i*DUTY_BITS +: DUTY_BITS]
//   pwm          : registered PWM outputs, bit i = channel i
//   period_start : one-cycle pulse when the shared counter wraps to 0
//   active_width : applied width per channel, channel i at [i*CW +: CW]
interface pwm_multi_gen_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PERIOD    = 400000,
    parameter int unsigned DUTY_BITS = 8
);
    localparam int unsigned CW = $clog2(PERIOD + 1);

    logic                          enable;
    logic [CHANNELS*DUTY_BITS-1:0] duty;
    logic [CHANNELS-1:0]           pwm;
    logic                          period_start;
    logic [CHANNELS*CW-1:0]        active_width;

    modport master (
        output enable, duty,
        input  pwm, period_start, active_width
    );

    modport slave (
        input  enable, duty,
        output pwm, period_start, active_width
    );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator sharing one period counter.
// Each channel clamps its duty-derived width to [MIN_WIDTH, MAX_WIDTH],
// applies width changes only at the period wrap, and slew-limits them.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : pwm_multi_gen_if slave (enable, duty in; pwm, period_start,
//           active_width out)
module pwm_multi_gen #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PERIOD    = 400000,
    parameter int unsigned MIN_WIDTH = 200000,
    parameter int unsigned MAX_WIDTH = 360000,
    parameter int unsigned DUTY_BITS = 8,
    parameter int unsigned SLEW_STEP = 40000
) (
    input logic           clk,
    input logic           reset,
    pwm_multi_gen_if.slave bus
);
    localparam int unsigned CW = $clog2(PERIOD + 1);
    localparam int unsigned PW = DUTY_BITS + CW;
    // A step larger than the period behaves as unlimited; capping keeps it in CW bits.
    localparam int unsigned STEP = (SLEW_STEP > PERIOD) ? PERIOD : SLEW_STEP;

    localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] MIN_W  = CW'(MIN_WIDTH);
    localparam logic [CW-1:0] MAX_W  = CW'(MAX_WIDTH);
    localparam logic [CW-1:0] STEP_W = CW'(STEP);
    localparam logic [PW-1:0] MIN_P  = PW'(MIN_WIDTH);
    localparam logic [PW-1:0] MAX_P  = PW'(MAX_WIDTH);

    if (MIN_WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("pwm_multi_gen: MIN_WIDTH must not exceed MAX_WIDTH");
    end

    logic [CW-1:0]                count_q, count_d;
    logic [CHANNELS-1:0][CW-1:0]  width_q, width_d;
    logic [CHANNELS-1:0]          pwm_q, pwm_d;
    logic                         ps_q, ps_d;
    logic                         wrap;
    logic [CHANNELS-1:0][PW-1:0]  prod, scaled;
    logic [CHANNELS-1:0][CW-1:0]  target, diff;

    always_comb begin
        wrap    = bus.enable && (count_q == LAST);
        count_d = (!bus.enable || wrap) ? '0 : count_q + CW'(1);
        ps_d    = wrap;
        prod    = '0;
        scaled  = '0;
        target  = '0;
        diff    = '0;
        width_d = width_q;
        pwm_d   = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            prod[ch]   = PW'(bus.duty[ch*DUTY_BITS +: DUTY_BITS]) * PW'(PERIOD);
            scaled[ch] = prod[ch] >> DUTY_BITS;
            if (scaled[ch] < MIN_P)      target[ch] = MIN_W;
            else if (scaled[ch] > MAX_P) target[ch] = MAX_W;
            else                         target[ch] = scaled[ch][CW-1:0];

            // Step toward target; the branch taken guarantees no wrap-around.
            if (!bus.enable) begin
                width_d[ch] = MIN_W;
            end else if (wrap) begin
                if (STEP == 0) begin
                    width_d[ch] = target[ch];
                end else if (target[ch] > width_q[ch]) begin
                    diff[ch]    = target[ch] - width_q[ch];
                    width_d[ch] = (diff[ch] > STEP_W) ? width_q[ch] + STEP_W : target[ch];
                end else begin
                    diff[ch]    = width_q[ch] - target[ch];
                    width_d[ch] = (diff[ch] > STEP_W) ? width_q[ch] - STEP_W : target[ch];
                end
            end

            // Compares against the width in force for the current count, so a
            // new width only affects the period that starts at count 0.
            pwm_d[ch] = bus.enable && (count_q < width_q[ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            pwm_q   <= '0;
            ps_q    <= 1'b0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                width_q[ch] <= MIN_W;
            end
        end else begin
            count_q <= count_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
            width_q <= width_d;
        end
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_start = ps_q;
    assign bus.active_width = width_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: PERIOD=100, MIN=50, MAX=90, DUTY_BITS=8, 4 channels.
// DUT A uses SLEW_STEP=10, DUT B uses SLEW_STEP=0.
module tb_pwm_multi_gen;
    localparam int CW = 7;

    typedef struct packed {
        logic [3:0][7:0] hc;
        logic [3:0][7:0] aw;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    pwm_multi_gen_if #(.CHANNELS(4), .PERIOD(100), .DUTY_BITS(8)) ifa ();
    pwm_multi_gen_if #(.CHANNELS(4), .PERIOD(100), .DUTY_BITS(8)) ifb ();

    pwm_multi_gen #(
        .CHANNELS(4), .PERIOD(100), .MIN_WIDTH(50), .MAX_WIDTH(90),
        .DUTY_BITS(8), .SLEW_STEP(10)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    pwm_multi_gen #(
        .CHANNELS(4), .PERIOD(100), .MIN_WIDTH(50), .MAX_WIDTH(90),
        .DUTY_BITS(8), .SLEW_STEP(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] widths(input logic [4*CW-1:0] v);
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++) r[i] = {1'b0, v[i*CW +: CW]};
        return r;
    endfunction

    function automatic logic [3:0][7:0] all4(input int v);
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++) r[i] = 8'(v);
        return r;
    endfunction

    function automatic exp_t mk(input int h0, h1, h2, h3, a0, a1, a2, a3);
        exp_t e;
        e.hc[0] = 8'(h0); e.hc[1] = 8'(h1); e.hc[2] = 8'(h2); e.hc[3] = 8'(h3);
        e.aw[0] = 8'(a0); e.aw[1] = 8'(a1); e.aw[2] = 8'(a2); e.aw[3] = 8'(a3);
        return e;
    endfunction

    // Monitor A: high cycles per completed period and width applied at the wrap.
    initial begin
        logic [3:0][7:0] hc;
        exp_t e;
        hc = '0;
        forever begin
            @(negedge clk);
            if (reset || !ifa.enable) begin
                hc = '0;
            end else begin
                for (int i = 0; i < 4; i++) hc[i] += {7'b0, ifa.pwm[i]};
                if (ifa.period_start) begin
                    check("A entry available", 64'(qa.size() > 0), 64'd1);
                    if (qa.size() > 0) begin
                        e = qa.pop_front();
                        check("A high cycles", hc, e.hc);
                        check("A active_width", widths(ifa.active_width), e.aw);
                    end
                    hc = '0;
                end
            end
        end
    end

    // Monitor B (unlimited slew).
    initial begin
        logic [3:0][7:0] hc;
        exp_t e;
        hc = '0;
        forever begin
            @(negedge clk);
            if (reset || !ifb.enable) begin
                hc = '0;
            end else begin
                for (int i = 0; i < 4; i++) hc[i] += {7'b0, ifb.pwm[i]};
                if (ifb.period_start) begin
                    check("B entry available", 64'(qb.size() > 0), 64'd1);
                    if (qb.size() > 0) begin
                        e = qb.pop_front();
                        check("B high cycles", hc, e.hc);
                        check("B active_width", widths(ifb.active_width), e.aw);
                    end
                    hc = '0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ifa.period_start && n < 300);
        check({name, " boundary seen"}, 64'(ifa.period_start), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0][7:0] w;
        reset = 1'b1;
        ifa.enable = 1'b0; ifa.duty = '0;
        ifb.enable = 1'b0; ifb.duty = '0;
        cyc(3);
        check("reset pwm", 64'(ifa.pwm), 64'd0);
        check("reset period_start", 64'(ifa.period_start), 64'd0);
        check("reset widths A", widths(ifa.active_width), all4(50));
        check("reset widths B", widths(ifb.active_width), all4(50));

        reset = 1'b0;
        ifa.duty = {8'd230, 8'd0, 8'd0, 8'd255};
        ifb.duty = {8'd230, 8'd0, 8'd192, 8'd255};
        cyc(2);
        check("idle pwm while disabled", 64'(ifa.pwm), 64'd0);

        qa.push_back(mk(50, 50, 50, 50, 60, 50, 50, 60));
        qb.push_back(mk(50, 50, 50, 50, 90, 75, 50, 89));
        qb.push_back(mk(90, 75, 50, 89, 90, 75, 50, 89));
        ifa.enable = 1'b1; ifb.enable = 1'b1;
        wait_ps("P1", n);
        check("P1 length", 64'(n), 64'd100);

        qa.push_back(mk(60, 50, 50, 60, 70, 50, 60, 70));
        cyc(30);
        ifa.duty[23:16] = 8'd255;
        wait_ps("P2", n);
        check("P2 length", 64'(n), 64'd70);
        cyc(1);
        ifb.enable = 1'b0;

        qa.push_back(mk(70, 50, 60, 70, 80, 50, 70, 80));
        wait_ps("P3", n);
        qa.push_back(mk(80, 50, 70, 80, 90, 50, 80, 89));
        wait_ps("P4", n);
        qa.push_back(mk(90, 50, 80, 89, 90, 50, 90, 89));
        wait_ps("P5", n);
        qa.push_back(mk(90, 50, 90, 89, 90, 50, 90, 79));
        cyc(20);
        ifa.duty[31:24] = 8'd0;
        wait_ps("P6", n);
        qa.push_back(mk(90, 50, 90, 79, 90, 50, 90, 69));
        wait_ps("P7", n);

        cyc(40);
        check("pwm high before disable", 64'(ifa.pwm), 64'hF);
        ifa.enable = 1'b0;
        cyc(1);
        check("disable pwm", 64'(ifa.pwm), 64'd0);
        check("disable period_start", 64'(ifa.period_start), 64'd0);
        check("disable widths", widths(ifa.active_width), all4(50));
        cyc(5);

        qa.push_back(mk(50, 50, 50, 50, 60, 50, 60, 50));
        ifa.enable = 1'b1;
        wait_ps("R1", n);
        check("re-enable first period_start delay", 64'(n), 64'd100);
        qa.push_back(mk(60, 50, 60, 50, 70, 50, 70, 50));
        wait_ps("R2", n);
        qa.push_back(mk(70, 50, 70, 50, 80, 50, 80, 50));
        wait_ps("R3", n);
        qa.push_back(mk(80, 50, 80, 50, 90, 50, 90, 50));
        wait_ps("R4", n);

        cyc(70);
        w = widths(ifa.active_width);
        check("ch0 width before reset", 64'(w[0]), 64'd90);
        check("pwm0 high before reset", 64'(ifa.pwm[0]), 64'd1);
        reset = 1'b1;
        cyc(1);
        check("mid-period reset pwm", 64'(ifa.pwm), 64'd0);
        check("mid-period reset period_start", 64'(ifa.period_start), 64'd0);
        check("mid-period reset widths", widths(ifa.active_width), all4(50));
        reset = 1'b0;

        qa.push_back(mk(50, 50, 50, 50, 60, 50, 60, 50));
        wait_ps("R5", n);
        check("post-reset period length", 64'(n), 64'd100);
        cyc(2);
        check("A queue drained", 64'(qa.size()), 64'd0);
        check("B queue drained", 64'(qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Multi-channel, parametrised PWM generator. It is the successor to the single-channel motor/servo PWM block. All channels share one period counter. Each channel clamps its duty to a safe [MIN_WIDTH, MAX_WIDTH] window, updates glitch-free only at period boundaries, and slew-limits width changes. It sits between the PWM register interface and the motor-driver pins.

Parameters:
CHANNELS, 4, number of independent PWM outputs
PERIOD, 400000, clock cycles per PWM period (counter runs 0..PERIOD-1)
MIN_WIDTH, 200000, minimum high cycles per period (hardware safety floor)
MAX_WIDTH, 360000, maximum high cycles per period (hardware safety ceiling)
DUTY_BITS, 8, width of each channel's duty code
SLEW_STEP, 40000, maximum change of active width per period; 0 = unlimited

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  global run enable; low forces outputs idle
duty  input  CHANNELS*DUTY_BITS  packed duty codes; channel i at [i*DUTY_BITS +: DUTY_BITS]
pwm  output  CHANNELS  registered PWM outputs, bit i = channel i
period_start  output  1  one-cycle pulse when the counter wraps to 0
active_width  output  CHANNELS*CW  current applied width per channel, CW = $clog2(PERIOD+1)

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) sets: count=0, pwm=0, period_start=0, every active_width=MIN_WIDTH. Reset mid-period takes effect at the next edge with no partial pulse afterwards.
- Counter: if enable=1, count increments each cycle and wraps from PERIOD-1 to 0, so the period is exactly PERIOD cycles. If enable=0, count is held at 0.
- Target width per channel is combinational: target = (duty_i * PERIOD) >> DUTY_BITS.
  - The product is computed at DUTY_BITS+CW bits with no overflow.
  - The result is clamped: below MIN_WIDTH becomes MIN_WIDTH; above MAX_WIDTH becomes MAX_WIDTH.
  - If MIN_WIDTH > MAX_WIDTH the configuration is illegal; elaboration must fail.
- Width update happens only on the edge where count goes PERIOD-1 -> 0, with enable=1:
  - If SLEW_STEP=0: active_width <= target.
  - Otherwise: active_width moves toward target by min(|target-active_width|, SLEW_STEP).
  - Duty changes at any other time have no effect until the next boundary. There are no mid-period glitches.
- Output: pwm_i <= enable & (count < active_width_i), registered. pwm therefore lags count by one cycle. The compare against the new width starts at count=0.
- period_start <= 1 on the edge where count wraps to 0 (enable=1); otherwise 0.
- Enable deasserted (enable=0):
  - On the next edge pwm=0, count=0, and active_width=MIN_WIDTH for all channels.
  - Re-assertion begins a fresh period from count=0 and ramps from MIN_WIDTH.
  - There is no period_start pulse on re-enable; the first pulse comes at the first wrap.
- Simultaneous reset and enable: reset wins.
- Channels are fully independent apart from the shared counter and enable.

Test Plan (PERIOD=100, MIN_WIDTH=50, MAX_WIDTH=90, DUTY_BITS=8, SLEW_STEP=10, CHANNELS=4):
- Reset then enable=1, duty all 0 -> every pwm high exactly 50 cycles per 100-cycle period; period_start pulses once every 100 cycles.
- ch0 duty=255 from reset -> target 99 clamped to 90; active_width sequence across boundaries is 60, 70, 80, 90, then pwm0 is high 90 of 100 cycles.
- ch1 duty=192 with SLEW_STEP=0 build -> active_width=75 at the first boundary; pwm1 is high 75 cycles per period.
- Change ch2 duty 0->255 at count=30 -> the current period keeps width 50; the next period has width 60 (slew); no glitch on pwm2.
- Drop enable at count=40 with pwm high -> pwm=0 next cycle, count=0, widths=50; re-enable -> first period is high 50 cycles, period_start first pulses 100 cycles later.
- Assert reset at count=70 with ch0 width 90 -> pwm0=0 next cycle; after release and enable, ch0 restarts from width 50.
